// File: rtl/serial_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : serial_frame_tx
// Description : Valid/ready word input, framed serial output on x:
//               start bit (1), WIDTH data bits, stop bit (0).
// Revision    : 1.0 - initial release
// ============================================================================
module serial_frame_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid,
    output logic             ready,
    output logic             x,
    output logic             busy,
    output logic             done
);

    localparam int c_cnt_w = $clog2(WIDTH);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_start = 2'd1;
    localparam logic [1:0] c_shift = 2'd2;
    localparam logic [1:0] c_stop  = 2'd3;

    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [WIDTH-1:0]   r_shift;
    logic [WIDTH-1:0]   w_shift_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic               w_out_bit;
    logic [WIDTH-1:0]   w_shifted;

    // Output end of the register and the value after one shift toward it
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_out_bit = r_shift[WIDTH-1];
            assign w_shifted = {r_shift[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_out_bit = r_shift[0];
            assign w_shifted = {1'b0, r_shift[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
            r_shift <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        ready       = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        x           = 1'b0;
        case (r_state)
            c_idle: begin
                ready = 1'b1;
                if (valid) begin
                    w_shift_nxt = data_in;
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_start;
                end
            end
            c_start: begin
                x           = 1'b1;
                busy        = 1'b1;
                w_state_nxt = c_shift;
            end
            c_shift: begin
                x           = w_out_bit;
                busy        = 1'b1;
                w_shift_nxt = w_shifted;
                // Counter holds on the last bit so it never wraps mid-frame
                if (r_cnt == c_last) begin
                    w_state_nxt = c_stop;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_w'(1);
                end
            end
            c_stop: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = c_idle;
            end
            default: begin
                ready       = 1'b1;
                w_state_nxt = c_idle;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_frame_tx
// Description : Randomized and directed bench for serial_frame_tx against a
//               frame-position reference model (MSB-first and LSB-first DUTs).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_frame_tx;

    localparam int c_w = 8;

    logic           clk = 1'b0;
    logic           r_rst;
    logic           r_valid;
    logic [c_w-1:0] r_data;

    logic w_ready_m, w_x_m, w_busy_m, w_done_m;
    logic w_ready_l, w_x_l, w_busy_l, w_done_l;

    int n_checks = 0;
    int n_pass   = 0;
    int n_done   = 0;
    int cyc_no   = 0;

    // Reference model: position within the frame, -1 when idle
    int             m_pos  = -1;
    logic [c_w-1:0] m_word = '0;

    always #5 clk = ~clk;

    serial_frame_tx #(.WIDTH(c_w), .MSB_FIRST(1'b1)) u_dut_msb (
        .clk(clk), .rst(r_rst), .data_in(r_data), .valid(r_valid),
        .ready(w_ready_m), .x(w_x_m), .busy(w_busy_m), .done(w_done_m)
    );

    serial_frame_tx #(.WIDTH(c_w), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk(clk), .rst(r_rst), .data_in(r_data), .valid(r_valid),
        .ready(w_ready_l), .x(w_x_l), .busy(w_busy_l), .done(w_done_l)
    );

    always @(posedge clk) begin
        if (r_rst) begin
            m_pos <= -1;
        end else if (m_pos < 0) begin
            if (r_valid) begin
                m_pos  <= 0;
                m_word <= r_data;
            end
        end else if (m_pos == c_w + 1) begin
            m_pos <= -1;
        end else begin
            m_pos <= m_pos + 1;
        end
    end

    // Expected {ready, busy, done, x} for a frame position
    function automatic logic [3:0] exp_vec(input int pos, input logic [c_w-1:0] w, input bit msb);
        logic b;
        if (pos < 0)  return 4'b1000;
        if (pos == 0) return 4'b0101;
        if (pos <= c_w) begin
            b = msb ? w[c_w - pos] : w[pos - 1];
            return {3'b010, b};
        end
        return 4'b0110;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc_no);
    endtask

    // Drive inputs for one cycle, then compare both DUTs with the model
    task automatic cyc(input logic rst_i, input logic valid_i, input logic [c_w-1:0] data_i);
        r_rst   = rst_i;
        r_valid = valid_i;
        r_data  = data_i;
        @(posedge clk);
        @(negedge clk);
        cyc_no++;
        if (w_done_m) n_done++;
        chk("msb_outputs", {28'd0, w_ready_m, w_busy_m, w_done_m, w_x_m}, {28'd0, exp_vec(m_pos, m_word, 1'b1)});
        chk("lsb_outputs", {28'd0, w_ready_l, w_busy_l, w_done_l, w_x_l}, {28'd0, exp_vec(m_pos, m_word, 1'b0)});
    endtask

    // Send one word from idle and collect 10 samples of x from both DUTs
    task automatic frame(input logic [c_w-1:0] d, output logic [9:0] fm, output logic [9:0] fl);
        fm = '0;
        fl = '0;
        for (int k = 0; k < 10; k++) begin
            if (k == 0) cyc(1'b0, 1'b1, d);
            else        cyc(1'b0, 1'b0, d);
            fm = {fm[8:0], w_x_m};
            fl = {fl[8:0], w_x_l};
        end
    endtask

    initial begin
        logic [9:0] fm, fl;
        int         d0, d1, dn;

        // Reset with a pending word: nothing may start
        cyc(1'b1, 1'b1, 8'hFF);
        cyc(1'b1, 1'b1, 8'hFF);
        chk("rst_idle", {29'd0, w_ready_m, w_busy_m, w_x_m}, 32'b100);
        cyc(1'b0, 1'b0, 8'h00);

        // Basic frame 0xA5
        frame(8'hA5, fm, fl);
        chk("a5_msb_stream", {22'd0, fm}, {22'd0, 10'b1101001010});
        cyc(1'b0, 1'b0, 8'h00);
        chk("a5_ready_again", {31'd0, w_ready_m}, 32'd1);

        // Bit order
        frame(8'h01, fm, fl);
        chk("01_msb_stream", {22'd0, fm}, {22'd0, 10'b1000000010});
        chk("01_lsb_stream", {22'd0, fl}, {22'd0, 10'b1100000000});
        cyc(1'b0, 1'b0, 8'h00);

        // New word offered while busy is ignored until the next idle cycle
        fm = '0;
        for (int k = 1; k <= 10; k++) begin
            if (k == 1)     cyc(1'b0, 1'b1, 8'hF0);
            else if (k < 3) cyc(1'b0, 1'b0, 8'hF0);
            else            cyc(1'b0, 1'b1, 8'h0F);
            fm = {fm[8:0], w_x_m};
        end
        chk("busy_ignore_stream", {22'd0, fm}, {22'd0, 10'b1111100000});
        cyc(1'b0, 1'b1, 8'h0F);
        chk("busy_ignore_accept", {31'd0, w_ready_m}, 32'd1);
        for (int k = 0; k < 12; k++) cyc(1'b0, 1'b0, 8'h00);

        // Back-to-back frames with valid held high
        d0 = -1; d1 = -1;
        for (int k = 1; k <= 22; k++) begin
            if (k == 1)       cyc(1'b0, 1'b1, 8'h80);
            else if (k <= 21) cyc(1'b0, 1'b1, 8'h01);
            else              cyc(1'b0, 1'b0, 8'h01);
            if (w_done_m) begin
                if (d0 < 0) d0 = k; else d1 = k;
            end
            if (k == 11) chk("b2b_idle_gap", {30'd0, w_ready_m, w_x_m}, 32'b10);
            if (k == 12) chk("b2b_second_start", {31'd0, w_x_m}, 32'd1);
        end
        chk("b2b_done_first", d0, 32'd10);
        chk("b2b_done_spacing", d1 - d0, 32'd11);

        // Reset in the middle of a frame
        dn = n_done;
        cyc(1'b0, 1'b1, 8'hFF);
        for (int k = 2; k <= 4; k++) cyc(1'b0, 1'b0, 8'hFF);
        cyc(1'b1, 1'b0, 8'hFF);
        chk("midrst_idle", {29'd0, w_ready_m, w_busy_m, w_x_m}, 32'b100);
        for (int k = 0; k < 6; k++) cyc(1'b0, 1'b0, 8'h00);
        chk("midrst_no_done", n_done - dn, 32'd0);
        frame(8'h3C, fm, fl);
        chk("midrst_next_stream", {22'd0, fm}, {22'd0, 10'b1001111000});
        cyc(1'b0, 1'b0, 8'h00);

        // Randomized traffic, occasional reset
        for (int k = 0; k < 600; k++) begin
            cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) != 0), c_w'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_frame_tx.md
# serial_frame_tx

Serial frame transmitter: it accepts a parallel word through a valid/ready handshake and emits it as a framed, one-bit-per-clock stream on `x`. The frame is one start bit, WIDTH data bits, then one stop bit. The block is the sending end of the single-bit serial input used by the lab's Moore sequence-detector FSMs, and drives their `x` input directly.

## Interface
Parameters:
- `WIDTH`, default 8: data word width; legal range ≥ 2.
- `MSB_FIRST`, default 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `data_in`  in  WIDTH  word to transmit; sampled only on an accepted handshake.
- `valid`  in  1  producer has a word on `data_in`.
- `ready`  out  1  block can accept a word this cycle.
- `x`  out  1  serial output stream.
- `busy`  out  1  frame in progress.
- `done`  out  1  one-cycle pulse during the stop bit.

## Operation
- Moore FSM with states IDLE, START, SHIFT and STOP. Every output is a function of the registered state, bit counter and shift register only; no combinational path from `valid` or `data_in` to any output.
- IDLE: `x`=0, `ready`=1, `busy`=0, `done`=0.
  - `valid` && `ready` at a rising edge: capture `data_in` into the shift register, clear the bit counter, go to START.
  - Otherwise stay in IDLE.
- START: `x`=1, `ready`=0, `busy`=1. Unconditionally go to SHIFT next cycle.
- SHIFT: `x` = current output bit of the shift register, `busy`=1.
  - Output bit is MSB if MSB_FIRST=1, LSB if MSB_FIRST=0.
  - Each cycle the register shifts by one toward the output end, filling with 0, and the counter increments.
  - After WIDTH cycles in SHIFT, when the counter reaches WIDTH-1, go to STOP.
- STOP: `x`=0, `done`=1, `busy`=1, `ready`=0. Unconditionally go to IDLE.
- Bit counter width is $clog2(WIDTH); it must not wrap within a frame.
- `valid` is ignored while `ready`=0. The word is not queued, and the producer must hold it until accepted.
- `data_in` changes after acceptance have no effect on the frame in flight.
- Unreachable state encodings go to IDLE with IDLE outputs.

## Timing
- Reset: `rst`=1 at a rising edge forces IDLE. Outputs the cycle after reset: `x`=0, `ready`=1, `busy`=0, `done`=0. The shift register and counter clear to 0.
- Reset mid-frame (any state) aborts the frame. The next cycle shows IDLE outputs; no `done` pulse is produced, and no partial data is retransmitted.
- `rst` has priority over a simultaneous handshake; the word is dropped.
- Handshake accepted at edge t0. Then:
  - Cycle t0+1: `x`=1 (start bit).
  - Cycles t0+2 … t0+WIDTH+1: data bits.
  - Cycle t0+WIDTH+2: `x`=0 and `done`=1.
  - Cycle t0+WIDTH+3: IDLE, `ready`=1.
- Frame length is WIDTH+2 cycles. Minimum spacing between accepted words is WIDTH+3 cycles.
- `valid` held high continuously gives back-to-back frames separated by exactly one IDLE cycle (`x`=0).

## Test plan
- Reset: `rst`=1 for 2 cycles with `valid`=1 and `data_in`=0xFF → after release `x`=0, `ready`=1, `busy`=0, `done`=0, and no frame is started during reset.
- Basic frame, WIDTH=8, MSB_FIRST=1, `data_in`=0xA5 accepted at t0:
  - `x` on t0+1…t0+10 = 1,1,0,1,0,0,1,0,1,0.
  - `done`=1 only at t0+10.
  - `ready`=1 again at t0+11.
- LSB order, MSB_FIRST=0, `data_in`=0x01 → `x` = 1 (start), 1,0,0,0,0,0,0,0, 0 (stop).
- Busy ignore: accept 0xF0; at t0+3 drive `data_in`=0x0F with `valid`=1 → the stream still carries 0xF0 (bits 1,1,1,1,0,0,0,0), and 0x0F is accepted only at t0+11.
- Back-to-back: `valid` held high with 0x80 then 0x01 → exactly one `x`=0 IDLE cycle between the first stop bit and the second start bit; two `done` pulses 11 cycles apart.
- Mid-frame reset: accept 0xFF, assert `rst` at t0+5 → at t0+6 `x`=0, `busy`=0, `ready`=1; `done` never pulses; the next accepted word transmits correctly.
